// File: rtl/z_core.sv
// rtl/z_core.sv - Processor Z core: fetch/execute FSM, instruction memory, register file
// Programs load through addr/wEn/wDat while idle; each instruction takes FETCH + EXEC.
module z_core #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int IMEM_DEPTH = 512,
  parameter int NREG       = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wEn,
  input  logic [31:0]       wDat,
  input  logic              working,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_dat,
  output logic [3:0]        icode,
  output logic [3:0]        ifun,
  output logic [3:0]        rA,
  output logic [3:0]        rB,
  output logic [15:0]       valC,
  output logic [DATA_W-1:0] valE,
  output logic [2:0]        cc,
  output logic [ADDR_W:0]   pc,
  output logic [1:0]        stat,
  output logic              retire
);

  localparam int              IW      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [3:0]      NREG_P  = 4'(NREG);
  localparam int              MSB     = DATA_W - 1;

  localparam logic [1:0] ST_AOK = 2'd0;
  localparam logic [1:0] ST_HLT = 2'd1;
  localparam logic [1:0] ST_INS = 2'd2;
  localparam logic [1:0] ST_ADR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_STOP} state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       mem [IMEM_DEPTH];
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [NREG];

  logic [3:0]        d_icode;
  logic [3:0]        d_ifun;
  logic [3:0]        d_ra;
  logic [3:0]        d_rb;
  logic [15:0]       d_valc;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic [DATA_W-1:0] result;
  logic              exc;
  logic              halt;
  logic              wr;
  logic              set_cc;
  logic              of;
  logic              fetch_bad;

  assign fetch_bad = (pc >= DEPTH_P);

  assign d_icode = ir[31:28];
  assign d_ifun  = ir[27:24];
  assign d_ra    = ir[23:20];
  assign d_rb    = ir[19:16];
  assign d_valc  = ir[15:0];

  // Loads are blocked while running, so the single port never sees a fetch and a write together.
  always_ff @(posedge clock) begin
    if (!reset && wEn && !working && ({1'b0, addr} < DEPTH_P)) begin
      mem[addr[IW-1:0]] <= wDat;
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_FETCH && !fetch_bad) begin
      ir <= mem[pc[IW-1:0]];
    end
  end

  always_comb begin
    dbg_dat = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dbg_sel == 4'(i)) dbg_dat = regs[i];
    end
  end

  always_comb begin
    ra_val = '0;
    rb_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (d_ra == 4'(i)) ra_val = regs[i];
      if (d_rb == 4'(i)) rb_val = regs[i];
    end
    exc    = 1'b0;
    halt   = 1'b0;
    wr     = 1'b0;
    set_cc = 1'b0;
    of     = 1'b0;
    result = '0;
    case (d_icode)
      4'h0: begin
        if (d_ifun != 4'h0) exc = 1'b1;
        else                halt = 1'b1;
      end
      4'h1: begin
        if (d_ifun != 4'h0) exc = 1'b1;
      end
      4'h3: begin
        if (d_ifun != 4'h0 || d_ra != 4'hF || d_rb >= NREG_P) begin
          exc = 1'b1;
        end else begin
          wr     = 1'b1;
          result = DATA_W'(d_valc);
        end
      end
      4'h6: begin
        if (d_ifun[3:2] != 2'b00 || d_ra >= NREG_P || d_rb >= NREG_P) begin
          exc = 1'b1;
        end else begin
          wr     = 1'b1;
          set_cc = 1'b1;
          // Overflow: operands that agree (ADD) or differ (SUB) in sign yet flip the result sign.
          case (d_ifun[1:0])
            2'd0: begin
              result = rb_val + ra_val;
              of     = (rb_val[MSB] == ra_val[MSB]) && (result[MSB] != rb_val[MSB]);
            end
            2'd1: begin
              result = rb_val - ra_val;
              of     = (rb_val[MSB] != ra_val[MSB]) && (result[MSB] != rb_val[MSB]);
            end
            2'd2:    result = rb_val & ra_val;
            default: result = rb_val ^ ra_val;
          endcase
        end
      end
      default: exc = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (working) state_next = S_FETCH;
      S_FETCH: state_next = fetch_bad ? S_STOP : S_EXEC;
      S_EXEC: begin
        if (exc || halt)  state_next = S_STOP;
        else if (working) state_next = S_FETCH;
        else              state_next = S_IDLE;
      end
      default: state_next = S_STOP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= '0;
      icode  <= '0;
      ifun   <= '0;
      rA     <= '0;
      rB     <= '0;
      valC   <= '0;
      valE   <= '0;
      cc     <= 3'b100;
      stat   <= ST_AOK;
      retire <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      if (state == S_FETCH && fetch_bad) begin
        stat <= ST_ADR;
      end
      if (state == S_EXEC) begin
        retire <= 1'b1;
        icode  <= d_icode;
        ifun   <= d_ifun;
        rA     <= d_ra;
        rB     <= d_rb;
        valC   <= d_valc;
        valE   <= result;
        pc     <= pc + 1'b1;
        if (exc)       stat <= ST_INS;
        else if (halt) stat <= ST_HLT;
        if (set_cc) cc <= {~|result, result[MSB], of};
        for (int i = 0; i < NREG; i++) begin
          if (wr && d_rb == 4'(i)) regs[i] <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_z_core.sv
// tb/tb_z_core.sv - randomized and directed bench for z_core against an instruction-level model
module tb_z_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  addr;
  logic        wEn;
  logic [31:0] wDat;
  logic        working;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_dat;
  logic [3:0]  icode, ifun, rA, rB;
  logic [15:0] valC;
  logic [31:0] valE;
  logic [2:0]  cc;
  logic [9:0]  pc;
  logic [1:0]  stat;
  logic        retire;

  logic [8:0]  addr4;
  logic        wEn4;
  logic [31:0] wDat4;
  logic        working4;
  logic [31:0] dbg_dat4;
  logic [3:0]  icode4, ifun4, rA4, rB4;
  logic [15:0] valC4;
  logic [31:0] valE4;
  logic [2:0]  cc4;
  logic [9:0]  pc4;
  logic [1:0]  stat4;
  logic        retire4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  z_core dut (
    .clock(clock), .reset(reset), .addr(addr), .wEn(wEn), .wDat(wDat), .working(working),
    .dbg_sel(dbg_sel), .dbg_dat(dbg_dat), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valE(valE), .cc(cc), .pc(pc), .stat(stat), .retire(retire)
  );

  z_core #(.DATA_W(32), .ADDR_W(9), .IMEM_DEPTH(4), .NREG(6)) dut4 (
    .clock(clock), .reset(reset), .addr(addr4), .wEn(wEn4), .wDat(wDat4), .working(working4),
    .dbg_sel(dbg_sel), .dbg_dat(dbg_dat4), .icode(icode4), .ifun(ifun4), .rA(rA4), .rB(rB4),
    .valC(valC4), .valE(valE4), .cc(cc4), .pc(pc4), .stat(stat4), .retire(retire4)
  );

  // Instruction-level reference: one call executes one whole instruction.
  logic [31:0] m_mem [512];
  logic [31:0] m_reg [6];
  logic [2:0]  m_cc;
  logic [1:0]  m_stat;
  int          m_pc;
  int          m_retired;
  logic [31:0] m_vale;
  logic [15:0] m_valc;
  logic [15:0] m_fields;
  logic [31:0] dregs [6];

  task automatic model_reset;
    for (int i = 0; i < 6; i++) m_reg[i] = 32'h0;
    m_cc = 3'b100; m_stat = 2'd0; m_pc = 0; m_vale = 0; m_valc = 0; m_fields = 0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    int ic, fn, ra, rb;
    longint a, b, full;
    logic [31:0] res;
    ic = int'(w[31:28]); fn = int'(w[27:24]); ra = int'(w[23:20]); rb = int'(w[19:16]);
    m_fields = w[31:16];
    m_valc = w[15:0];
    m_vale = 0;
    m_retired++;
    m_pc++;
    case (ic)
      0: m_stat = (fn == 0) ? 2'd1 : 2'd2;
      1: if (fn != 0) m_stat = 2'd2;
      3: begin
        if (fn != 0 || ra != 15 || rb >= 6) m_stat = 2'd2;
        else begin
          m_reg[rb] = {16'h0, w[15:0]};
          m_vale = {16'h0, w[15:0]};
        end
      end
      6: begin
        if (fn > 3 || ra >= 6 || rb >= 6) m_stat = 2'd2;
        else begin
          a = longint'($signed(m_reg[ra]));
          b = longint'($signed(m_reg[rb]));
          case (fn)
            0: full = b + a;
            1: full = b - a;
            2: full = longint'($signed(m_reg[rb] & m_reg[ra]));
            default: full = longint'($signed(m_reg[rb] ^ m_reg[ra]));
          endcase
          res = full[31:0];
          m_reg[rb] = res;
          m_vale = res;
          m_cc = {res == 0, res[31], full != longint'($signed(res))};
        end
      end
      default: m_stat = 2'd2;
    endcase
  endtask

  task automatic model_run(input int depth);
    m_retired = 0;
    while (m_stat == 2'd0) begin
      if (m_pc >= depth) m_stat = 2'd3;
      else model_exec(m_mem[m_pc]);
    end
  endtask

  task automatic do_reset;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    addr = a; wDat = d; wEn = 1'b1;
    @(posedge clock); #1;
    wEn = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic load4(input logic [8:0] a, input logic [31:0] d);
    addr4 = a; wDat4 = d; wEn4 = 1'b1;
    @(posedge clock); #1;
    wEn4 = 1'b0;
  endtask

  task automatic snap_regs;
    for (int i = 0; i < 6; i++) begin
      dbg_sel = 4'(i);
      #1;
      dregs[i] = dbg_dat;
    end
  endtask

  task automatic run_core(input int budget, output int nret, output int last);
    int cyc;
    @(posedge clock); #1;
    nret = 0; last = -1; cyc = 0;
    working = 1'b1;
    @(posedge clock); #1;
    while (stat == 2'd0 && cyc < budget) begin
      @(posedge clock); #1;
      cyc++;
      if (retire) begin nret++; last = cyc; end
    end
    working = 1'b0;
    checks++;
    if (stat == 2'd0) begin
      errors++;
      $display("FAIL run_timeout: stat=%0d after %0d cycles, required nonzero", stat, cyc);
    end
  endtask

  task automatic test_reset;
    working = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({pc, stat, cc, retire} !== {10'd0, 2'd0, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: pc=%0d stat=%0d cc=%b retire=%b, required 0 0 100 0", pc, stat, cc, retire);
    end
    checks++;
    if ({icode, ifun, rA, rB, valC, valE} !== 64'h0) begin
      errors++;
      $display("FAIL reset_fields: %h %h %h %h %h %h, required all 0", icode, ifun, rA, rB, valC, valE);
    end
    reset = 1'b0;
    working = 1'b0;
    model_reset();
  endtask

  task automatic test_program;
    int nret, last;
    do_reset();
    load(0, 32'h30F00005); load(1, 32'h30F10003); load(2, 32'h61010000); load(3, 32'h00000000);
    run_core(100, nret, last);
    model_run(512);
    snap_regs();
    checks++;
    if (dregs[0] !== 32'h5 || dregs[1] !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL prog_regs: r0=%h r1=%h, required 5 fffffffe", dregs[0], dregs[1]);
    end
    checks++;
    if (cc !== 3'b010 || stat !== 2'd1 || pc !== 10'd4) begin
      errors++;
      $display("FAIL prog_status: cc=%b stat=%0d pc=%0d, required 010 1 4", cc, stat, pc);
    end
    checks++;
    if (nret != 4 || last != 8) begin
      errors++;
      $display("FAIL prog_retire: count=%0d last=%0d, required 4 8", nret, last);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dregs[i] !== m_reg[i]) begin
        errors++;
        $display("FAIL prog_model_r%0d: got %h, required %h", i, dregs[i], m_reg[i]);
      end
    end
  endtask

  task automatic test_overflow_xor;
    int nret, last;
    do_reset();
    load(0, 32'h30F08000);
    for (int i = 1; i <= 16; i++) load(9'(i), 32'h60000000);
    load(17, 32'h30F10001); load(18, 32'h61100000); load(19, 32'h60010000); load(20, 32'h00000000);
    run_core(200, nret, last);
    model_run(512);
    snap_regs();
    checks++;
    if (dregs[0] !== 32'h7FFFFFFF || dregs[1] !== 32'h80000000 || cc !== 3'b011) begin
      errors++;
      $display("FAIL add_overflow: r0=%h r1=%h cc=%b, required 7fffffff 80000000 011", dregs[0], dregs[1], cc);
    end
    checks++;
    if (cc !== m_cc || valE !== m_vale) begin
      errors++;
      $display("FAIL add_model: cc=%b valE=%h, required %b %h", cc, valE, m_cc, m_vale);
    end
    do_reset();
    load(20, 32'h63110000); load(21, 32'h00000000);
    run_core(200, nret, last);
    snap_regs();
    checks++;
    if (dregs[1] !== 32'h0 || cc !== 3'b100 || stat !== 2'd1 || pc !== 10'd22) begin
      errors++;
      $display("FAIL xor_self: r1=%h cc=%b stat=%0d pc=%0d, required 0 100 1 22", dregs[1], cc, stat, pc);
    end
  endtask

  task automatic test_bad_encoding;
    int nret, last;
    logic [31:0] bad [3];
    bad[0] = 32'h30F60001; bad[1] = 32'h70000000; bad[2] = 32'h64010000;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      load(0, 32'h30F01234); load(1, bad[k]); load(2, 32'h00000000);
      run_core(50, nret, last);
      model_run(512);
      snap_regs();
      checks++;
      if (stat !== 2'd2 || pc !== 10'd2 || valE !== 32'h0 || {icode, ifun, rA, rB} !== bad[k][31:16]) begin
        errors++;
        $display("FAIL bad_enc%0d: stat=%0d pc=%0d valE=%h fields=%h, required 2 2 0 %h",
                 k, stat, pc, valE, {icode, ifun, rA, rB}, bad[k][31:16]);
      end
      checks++;
      if (dregs[0] !== 32'h1234 || dregs[1] !== 32'h0 || dregs[5] !== 32'h0 || cc !== 3'b100) begin
        errors++;
        $display("FAIL bad_enc%0d_state: r0=%h r1=%h r5=%h cc=%b, required 1234 0 0 100",
                 k, dregs[0], dregs[1], dregs[5], cc);
      end
    end
  endtask

  task automatic test_adr_wrap;
    int nret, cyc;
    do_reset();
    for (int i = 0; i < 4; i++) load4(9'(i), 32'h10000000);
    nret = 0; cyc = 0;
    working4 = 1'b1;
    while (stat4 == 2'd0 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
      if (retire4) nret++;
    end
    repeat (5) begin
      @(posedge clock); #1;
      if (retire4) nret++;
    end
    working4 = 1'b0;
    checks++;
    if (stat4 !== 2'd3 || pc4 !== 10'd4) begin
      errors++;
      $display("FAIL adr_status: stat=%0d pc=%0d, required 3 4", stat4, pc4);
    end
    checks++;
    if (nret != 4) begin
      errors++;
      $display("FAIL adr_retire: count=%0d, required 4", nret);
    end
  endtask

  task automatic test_pause;
    int nret, rn, last;
    do_reset();
    for (int i = 0; i < 8; i++) load(9'(i), {12'h30F, 4'(i % 6), 16'($urandom)});
    load(8, 32'h00000000);
    nret = 0;
    working = 1'b1;
    @(posedge clock); #1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clock); #1;
      if (retire) nret++;
    end
    working = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      if (retire) nret++;
    end
    checks++;
    if (nret != 2 || pc !== 10'd2 || stat !== 2'd0) begin
      errors++;
      $display("FAIL pause_state: retires=%0d pc=%0d stat=%0d, required 2 2 0", nret, pc, stat);
    end
    load(5, 32'h30F3BEEF);
    run_core(100, rn, last);
    model_run(512);
    snap_regs();
    checks++;
    if (dregs[3] !== 32'h0000BEEF || pc !== 10'd9 || stat !== 2'd1) begin
      errors++;
      $display("FAIL pause_resume: r3=%h pc=%0d stat=%0d, required 0000beef 9 1", dregs[3], pc, stat);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dregs[i] !== m_reg[i]) begin
        errors++;
        $display("FAIL pause_model_r%0d: got %h, required %h", i, dregs[i], m_reg[i]);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int nret, last, idle_bad;
    do_reset();
    for (int i = 0; i < 10; i++) load(9'(i), {12'h30F, 4'($urandom_range(0, 5)), 16'($urandom)});
    load(10, 32'h60000000); load(11, 32'h00000000);
    working = 1'b1;
    repeat (7) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    snap_regs();
    checks++;
    if ({pc, stat, cc, retire, icode, ifun, rA, rB, valC, valE} !== {10'd0, 2'd0, 3'b100, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL midrun_reset: pc=%0d stat=%0d cc=%b retire=%b valE=%h valC=%h", pc, stat, cc, retire, valE, valC);
    end
    checks++;
    if ((dregs[0] | dregs[1] | dregs[2] | dregs[3] | dregs[4] | dregs[5]) !== 32'h0) begin
      errors++;
      $display("FAIL midrun_regs: or of regs=%h, required 0", dregs[0] | dregs[1] | dregs[2] | dregs[3] | dregs[4] | dregs[5]);
    end
    reset = 1'b0;
    working = 1'b0;
    model_reset();
    idle_bad = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (pc !== 10'd0 || retire !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL midrun_idle: %0d cycles moved, required 0", idle_bad);
    end
    run_core(100, nret, last);
    model_run(512);
    snap_regs();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dregs[i] !== m_reg[i]) begin
        errors++;
        $display("FAIL midrun_rerun_r%0d: got %h, required %h", i, dregs[i], m_reg[i]);
      end
    end
  endtask

  task automatic test_random;
    int n, nret, last, kind;
    logic [31:0] w;
    for (int it = 0; it < 5; it++) begin
      do_reset();
      n = $urandom_range(8, 24);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        if (kind < 4)       w = {12'h30F, 4'($urandom_range(0, 5)), 16'($urandom)};
        else if (kind == 4) w = 32'h10000000;
        else w = {4'h6, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 16'($urandom)};
        load(9'(i), w);
      end
      load(9'(n), 32'h00000000);
      run_core(2 * n + 40, nret, last);
      model_run(512);
      snap_regs();
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dregs[i] !== m_reg[i]) begin
          errors++;
          $display("FAIL rand%0d_r%0d: got %h, required %h", it, i, dregs[i], m_reg[i]);
        end
      end
      checks++;
      if (cc !== m_cc || stat !== m_stat || pc !== 10'(m_pc)) begin
        errors++;
        $display("FAIL rand%0d_status: cc=%b stat=%0d pc=%0d, required %b %0d %0d", it, cc, stat, pc, m_cc, m_stat, m_pc);
      end
      checks++;
      if (valE !== m_vale || {icode, ifun, rA, rB} !== m_fields || valC !== m_valc) begin
        errors++;
        $display("FAIL rand%0d_fields: valE=%h f=%h valC=%h, required %h %h %h",
                 it, valE, {icode, ifun, rA, rB}, valC, m_vale, m_fields, m_valc);
      end
      checks++;
      if (nret != m_retired || last != 2 * m_retired) begin
        errors++;
        $display("FAIL rand%0d_retire: count=%0d last=%0d, required %0d %0d", it, nret, last, m_retired, 2 * m_retired);
      end
      for (int s = 6; s < 16; s++) begin
        dbg_sel = 4'(s);
        #1;
        checks++;
        if (dbg_dat !== 32'h0) begin
          errors++;
          $display("FAIL rand%0d_dbg_sel%0d: got %h, required 0", it, s, dbg_dat);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; addr = '0; wEn = 1'b0; wDat = '0; working = 1'b0; dbg_sel = '0;
    addr4 = '0; wEn4 = 1'b0; wDat4 = '0; working4 = 1'b0;
    for (int i = 0; i < 512; i++) m_mem[i] = 32'h0;
    test_reset();
    test_program();
    test_overflow_xor();
    test_bad_encoding();
    test_adr_wrap();
    test_pause();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
